output_port_4: RTL and testbench
================================

OUTPUT_PORT_4 -- requirements
Module: output_port_4

Interface
REQ-001 The module SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 Parameter BIT_TICKS, default 1, SHALL set the number of CLK cycles each serial bit is held (legal range 1..255).
REQ-003 Port CLK, input, 1, SHALL be the system clock; all state changes occur on its rising edge.
REQ-004 Port CLR, input, 1, SHALL be the asynchronous active-high clear.
REQ-005 Port WBUS, input, 8, SHALL carry the byte to be transmitted.
REQ-006 Port Lo4, input, 1, SHALL request loading of WBUS into the port.
REQ-007 Port ack, input, 1, SHALL be the acknowledge returned by the receiving device.
REQ-008 Port serial_out, output, 1, SHALL carry the serial data bit.
REQ-009 Port ready, output, 1, SHALL mark a valid serial bit on serial_out and pairs with the receiver's ready input.
REQ-010 Ports busy, done and overrun, outputs, 1 each, SHALL report the states defined under Function.

Function
REQ-011 The state machine SHALL have exactly four states: IDLE, SHIFT, PARITY (see REQ-030) and WAIT_ACK.
REQ-012 In IDLE, a sampled Lo4=1 SHALL capture WBUS into an 8-bit shift register, clear the bit and tick counters, and enter SHIFT.
REQ-013 In SHIFT, the outputs SHALL be ready=1 and serial_out=shift register bit 0; transmission is LSB first.
REQ-014 Each bit SHALL be held for exactly BIT_TICKS cycles; the register then shifts right one place, filling with 0.
REQ-015 After the 8th bit completes, the FSM SHALL enter WAIT_ACK, or PARITY when that feature is compiled in.
REQ-016 Latency: Lo4 sampled at edge k SHALL give ready=1 and bit 0 on serial_out from edge k to edge k+BIT_TICKS.
REQ-017 With BIT_TICKS=1, a frame SHALL occupy exactly 8 cycles.
REQ-018 In WAIT_ACK, the outputs SHALL be ready=0 and serial_out=0; the FSM stays in WAIT_ACK until ack=1 is sampled.
REQ-019 On the edge that samples ack=1 in WAIT_ACK, the FSM SHALL return to IDLE and drive done=1 for exactly one cycle.
REQ-020 ack SHALL be ignored in IDLE, SHIFT and PARITY.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Lo4 sampled while busy=1 SHALL be ignored for data and SHALL set overrun=1 (sticky).
REQ-023 overrun SHALL clear on the next accepted load or on CLR.
REQ-024 In the cycle done=1 the FSM is in IDLE, so a Lo4 sampled then SHALL be accepted as a new load.
REQ-025 When Lo4 and ack are sampled on the same WAIT_ACK edge, ack SHALL be processed, Lo4 dropped and overrun set.
REQ-026 WBUS changes after the load edge SHALL NOT affect the frame in flight.

Reset
REQ-027 CLR=1 SHALL immediately force state IDLE; shift register, tick counter and bit counter to 0; serial_out=0, ready=0, busy=0, done=0, overrun=0.
REQ-028 CLR asserted mid-frame SHALL abort the frame with no done pulse; transmission SHALL restart only on a new Lo4 after CLR deasserts.
REQ-029 The first edge after CLR deasserts SHALL be able to accept Lo4.

Configuration
REQ-030 Macro OUTPUT_PORT_4_PARITY_EN defined: after bit 7 the FSM SHALL enter PARITY for BIT_TICKS cycles with ready=1 and serial_out = even parity (XOR of the loaded byte), then go to WAIT_ACK; a frame is 9 bit-times.
REQ-031 Macro OUTPUT_PORT_4_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent; SHIFT goes directly to WAIT_ACK.

Verification
REQ-032 BIT_TICKS=1, load 8'hA5, ack=1 held after frame -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles with ready=1, then ready=0 and a single done pulse.
REQ-033 BIT_TICKS=3, load 8'h01 -> serial_out=1 for 3 cycles, then 0 for 21 cycles, with ready=1 for all 24 cycles.
REQ-034 Load 8'h3C, second Lo4 with WBUS=8'hFF at cycle 4 -> transmitted byte stays 8'h3C, overrun=1 until the next accepted load.
REQ-035 CLR pulsed at cycle 5 of a 8'hF0 frame -> all outputs 0 at once, no done pulse, and the next load of 8'h0F transmits cleanly.
REQ-036 ack held 0 for 10 cycles after the frame -> FSM stays in WAIT_ACK with busy=1; ack=1 -> done pulse, then Lo4 in the done cycle is accepted.
REQ-037 OUTPUT_PORT_4_PARITY_EN defined, load 8'h07 -> 9th bit = 1; load 8'h03 -> 9th bit = 0.

Source files
------------

// File: rtl/output_port_4.sv
// Serial output port: loads a byte on Lo4, shifts it out LSB first with ready, then waits for ack.
// Optional even-parity bit after the data byte when OUTPUT_PORT_4_PARITY_EN is defined.
module output_port_4 #(
  parameter int BIT_TICKS = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] WBUS,
  input  logic       Lo4,
  input  logic       ack,
  output logic       serial_out,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd3;
`ifdef OUTPUT_PORT_4_PARITY_EN
  localparam logic [1:0] PARITY   = 2'd2;
`endif
  localparam logic [7:0] TICK_LAST = 8'(BIT_TICKS - 1);

  logic [1:0] state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] tick_reg, tick_next;
  logic [2:0] bit_reg, bit_next;
  logic       done_reg, done_next;
  logic       overrun_reg, overrun_next;
  logic       bit_end;
`ifdef OUTPUT_PORT_4_PARITY_EN
  logic       parity_reg, parity_next;
`endif

  assign bit_end = (tick_reg == TICK_LAST);

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    tick_next    = tick_reg;
    bit_next     = bit_reg;
    done_next    = 1'b0;
    overrun_next = overrun_reg;
`ifdef OUTPUT_PORT_4_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (Lo4) begin
          shift_next   = WBUS;
          tick_next    = '0;
          bit_next     = '0;
          overrun_next = 1'b0;
          state_next   = SHIFT;
`ifdef OUTPUT_PORT_4_PARITY_EN
          parity_next  = ^WBUS;
`endif
        end
      end
      SHIFT: begin
        if (bit_end) begin
          tick_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
`ifdef OUTPUT_PORT_4_PARITY_EN
            state_next = PARITY;
`else
            state_next = WAIT_ACK;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          tick_next = tick_reg + 8'd1;
        end
      end
`ifdef OUTPUT_PORT_4_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tick_next  = '0;
          state_next = WAIT_ACK;
        end else begin
          tick_next = tick_reg + 8'd1;
        end
      end
`endif
      WAIT_ACK: begin
        if (ack) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A load request while a frame is in progress is dropped but remembered.
    if (Lo4 && (state_reg != IDLE)) overrun_next = 1'b1;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      tick_reg    <= '0;
      bit_reg     <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef OUTPUT_PORT_4_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      tick_reg    <= tick_next;
      bit_reg     <= bit_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
`ifdef OUTPUT_PORT_4_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign overrun = overrun_reg;

`ifdef OUTPUT_PORT_4_PARITY_EN
  assign ready      = (state_reg == SHIFT) || (state_reg == PARITY);
  assign serial_out = (state_reg == SHIFT)  ? shift_reg[0] :
                      (state_reg == PARITY) ? parity_reg : 1'b0;
`else
  assign ready      = (state_reg == SHIFT);
  assign serial_out = (state_reg == SHIFT) ? shift_reg[0] : 1'b0;
`endif

endmodule

// File: tb/tb_output_port_4.sv
// Bench for output_port_4: two instances (BIT_TICKS=1 and 3) checked every cycle against a
// queue-of-timed-bits model, plus directed literal checks of the scenarios that pin the model.
module tb_output_port_4;

`ifdef OUTPUT_PORT_4_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] WBUS = 8'h00;
  logic       Lo4 = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] so_w, rd_w, bz_w, dn_w, ov_w;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int BT = (gi == 0) ? 1 : 3;

    output_port_4 #(.BIT_TICKS(BT)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .WBUS      (WBUS),
      .Lo4       (Lo4),
      .ack       (ack),
      .serial_out(so_w[gi]),
      .ready     (rd_w[gi]),
      .busy      (bz_w[gi]),
      .done      (dn_w[gi]),
      .overrun   (ov_w[gi])
    );

    // Model: a frame is a queue of expected serial_out values, one entry per clock cycle.
    bit q[$];
    bit waiting = 1'b0;
    bit m_done  = 1'b0;
    bit m_ov    = 1'b0;
    bit was_busy;
    bit exp_rd;
    bit exp_so;
    logic [7:0] byte_v;

    always @(posedge CLK) begin
      if (CLR) begin
        q.delete();
        waiting = 1'b0;
        m_done  = 1'b0;
        m_ov    = 1'b0;
      end else begin
        was_busy = (q.size() != 0) || waiting;
        m_done   = 1'b0;
        if (q.size() != 0) begin
          void'(q.pop_front());
          if (q.size() == 0) waiting = 1'b1;
        end else if (waiting) begin
          if (ack) begin
            waiting = 1'b0;
            m_done  = 1'b1;
          end
        end else if (Lo4) begin
          byte_v = WBUS;
          for (int b = 0; b < NB; b++)
            for (int t = 0; t < BT; t++)
              q.push_back((b < 8) ? byte_v[b[2:0]] : ^byte_v);
          m_ov = 1'b0;
          $display("inst%0d load %02h", gi, byte_v);
        end
        if (Lo4 && was_busy) m_ov = 1'b1;
      end
      #1;
      exp_rd = (q.size() != 0);
      exp_so = exp_rd ? q[0] : 1'b0;
      check($sformatf("inst%0d ready", gi),      rd_w[gi], exp_rd);
      check($sformatf("inst%0d serial_out", gi), so_w[gi], exp_so);
      check($sformatf("inst%0d busy", gi),       bz_w[gi], exp_rd || waiting);
      check($sformatf("inst%0d done", gi),       dn_w[gi], m_done);
      check($sformatf("inst%0d overrun", gi),    ov_w[gi], m_ov);
    end
  end

  task automatic step(input logic l, input logic a, input logic [7:0] w);
    Lo4  = l;
    ack  = a;
    WBUS = w;
    @(posedge CLK);
    #3;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bz_w != 2'b00) && (n < 200)) begin
      step(1'b0, 1'b1, 8'($urandom));
      n++;
    end
    check("drain to idle", int'(bz_w == 2'b00), 1);
  endtask

  logic [7:0] pat;

  initial begin
    #1 CLR = 1'b1;
    @(posedge CLK);
    #3;
    check("reset ready", rd_w, 0);
    check("reset serial_out", so_w, 0);
    check("reset busy", bz_w, 0);
    check("reset done", dn_w, 0);
    check("reset overrun", ov_w, 0);
    CLR = 1'b0;

    // A5 on the one-tick instance, ack already high during the frame
    pat = 8'b1010_0101;
    step(1'b1, 1'b0, 8'hA5);
    for (int i = 0; i < NB; i++) begin
      check("A5 bit", so_w[0], (i < 8) ? int'(pat[i[2:0]]) : 0);
      check("A5 ready", rd_w[0], 1);
      step(1'b0, 1'b1, 8'($urandom));
    end
    check("A5 wait ready", rd_w[0], 0);
    check("A5 wait busy", bz_w[0], 1);
    check("A5 wait done", dn_w[0], 0);
    step(1'b0, 1'b1, 8'($urandom));
    check("A5 done pulse", dn_w[0], 1);
    check("A5 idle busy", bz_w[0], 0);
    step(1'b0, 1'b1, 8'($urandom));
    check("A5 done single", dn_w[0], 0);
    wait_idle();

    // 01 on the three-tick instance; one-tick instance sits in WAIT_ACK with ack low
    step(1'b1, 1'b0, 8'h01);
    for (int i = 0; i < 3 * NB; i++) begin
      check("01 bit", so_w[1], (i < 3 || i >= 24) ? 1 : 0);
      check("01 ready", rd_w[1], 1);
      if (i >= NB) begin
        check("wait busy held", bz_w[0], 1);
        check("wait ready low", rd_w[0], 0);
      end
      step(1'b0, 1'b0, 8'($urandom));
    end
    check("01 end ready", rd_w[1], 0);
    check("01 end busy", bz_w[1], 1);
    step(1'b0, 1'b1, 8'($urandom));
    check("late ack done0", dn_w[0], 1);
    check("late ack done1", dn_w[1], 1);

    // load in the done cycle, then an overrun attempt with FF at cycle 4
    step(1'b1, 1'b0, 8'h3C);
    check("done-cycle load ready", rd_w[0], 1);
    check("done-cycle load overrun", ov_w[0], 0);
    pat = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check("3C bit", so_w[0], int'(pat[i[2:0]]));
      step(i == 3, 1'b0, (i == 3) ? 8'hFF : 8'($urandom));
    end
    check("overrun set", ov_w[0], 1);
    wait_idle();
    check("overrun sticky", ov_w[0], 1);

    // F0 aborted by CLR at cycle 5
    step(1'b1, 1'b0, 8'hF0);
    check("F0 load clears overrun", ov_w[0], 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'($urandom));
    CLR = 1'b1;
    #1;
    check("clr ready", rd_w, 0);
    check("clr serial_out", so_w, 0);
    check("clr busy", bz_w, 0);
    check("clr done", dn_w, 0);
    check("clr overrun", ov_w, 0);
    @(posedge CLK);
    #3;
    CLR = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'($urandom));
      check("no done after abort", dn_w[0], 0);
      check("idle after abort", bz_w[0], 0);
    end
    pat = 8'h0F;
    step(1'b1, 1'b0, 8'h0F);
    for (int i = 0; i < 8; i++) begin
      check("0F bit", so_w[0], int'(pat[i[2:0]]));
      step(1'b0, 1'b1, 8'($urandom));
    end
    wait_idle();

`ifdef OUTPUT_PORT_4_PARITY_EN
    step(1'b1, 1'b0, 8'h07);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'($urandom));
    check("07 parity bit", so_w[0], 1);
    check("07 parity ready", rd_w[0], 1);
    wait_idle();
    step(1'b1, 1'b0, 8'h03);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'($urandom));
    check("03 parity bit", so_w[0], 0);
    check("03 parity ready", rd_w[0], 1);
    wait_idle();
`endif

    // randomized traffic, including occasional mid-frame clears
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        CLR = 1'b1;
        step(1'b0, 1'b0, 8'($urandom));
        CLR = 1'b0;
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
      end
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
